// File: rtl/stopwatch_lap_controller.sv
// Stopwatch run/stop/clear/lap sequencer with a DEPTH-entry lap buffer and registered FND value select.
// Define AUTO_HOLD_TIMEOUT_EN to release a frozen lap display after HOLD_TICKS idle cycles.
module stopwatch_lap_controller #(
  parameter int VALUE_W    = 14,
  parameter int DEPTH      = 4,
  parameter int HOLD_TICKS = 300_000_000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_run_stop,
  input  logic                       i_clear,
  input  logic                       i_lap,
  input  logic [VALUE_W-1:0]         i_count_value,
  output logic                       o_run,
  output logic                       o_stop,
  output logic                       o_clear,
  output logic [VALUE_W-1:0]         o_value,
  output logic [$clog2(DEPTH+1)-1:0] o_lap_count,
  output logic                       o_lap_full,
  output logic                       o_recall
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HOLD, ST_STOP} state_t;

  state_t               state_q, state_d;
  logic [VALUE_W-1:0]   value_q, value_d;
  logic [CW-1:0]        lap_cnt_q, lap_cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 recall_q, recall_d;
  logic                 clear_q, clear_d;
  logic [VALUE_W-1:0]   lap_mem_q [DEPTH];

  logic                 rs_p, clr_p, lap_p;
  logic                 capture, wr_en, recall_step, full;
  logic [CW-1:0]        idx_inc;

  // Same-cycle pulses: run_stop beats clear beats lap.
  assign rs_p  = i_run_stop;
  assign clr_p = i_clear & ~i_run_stop;
  assign lap_p = i_lap & ~i_run_stop & ~i_clear;

  assign full    = (lap_cnt_q == DEPTH_C);
  assign idx_inc = CW'(idx_q) + CW'(1);

`ifdef AUTO_HOLD_TIMEOUT_EN
  localparam logic [31:0] HOLD_LAST = 32'(HOLD_TICKS - 1);
  logic [31:0] timer_q;
`else
  logic [31:0] unused_hold_ticks;
  assign unused_hold_ticks = 32'(HOLD_TICKS);
`endif

  always_comb begin
    state_d     = state_q;
    lap_cnt_d   = lap_cnt_q;
    idx_d       = idx_q;
    recall_d    = recall_q;
    clear_d     = 1'b0;
    capture     = 1'b0;
    wr_en       = 1'b0;
    recall_step = 1'b0;
    value_d     = i_count_value;

    case (state_q)
      ST_IDLE: begin
        if (rs_p) state_d = ST_RUN;
      end
      ST_RUN, ST_HOLD: begin
        if (rs_p) begin
          state_d = ST_STOP;
          idx_d   = '0;
        end else if (clr_p && state_q == ST_HOLD) begin
          state_d = ST_RUN;
        end else if (lap_p) begin
          // A full buffer still freezes the display; only the store is skipped.
          state_d = ST_HOLD;
          capture = 1'b1;
          if (!full) begin
            wr_en     = 1'b1;
            lap_cnt_d = lap_cnt_q + CW'(1);
          end
        end
`ifdef AUTO_HOLD_TIMEOUT_EN
        else if (state_q == ST_HOLD && timer_q == HOLD_LAST) begin
          state_d = ST_RUN;
        end
`endif
      end
      ST_STOP: begin
        if (rs_p) begin
          state_d  = ST_RUN;
          recall_d = 1'b0;
        end else if (clr_p) begin
          state_d   = ST_IDLE;
          clear_d   = 1'b1;
          lap_cnt_d = '0;
          recall_d  = 1'b0;
          idx_d     = '0;
        end else if (lap_p && lap_cnt_q != '0) begin
          recall_d    = 1'b1;
          recall_step = 1'b1;
          idx_d       = (idx_inc == lap_cnt_q) ? '0 : idx_inc[IW-1:0];
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_HOLD) begin
      value_d = capture ? i_count_value : value_q;
    end else if (state_d == ST_STOP && recall_d) begin
      value_d = recall_step ? lap_mem_q[idx_q] : value_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      value_q   <= '0;
      lap_cnt_q <= '0;
      idx_q     <= '0;
      recall_q  <= 1'b0;
      clear_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      value_q   <= value_d;
      lap_cnt_q <= lap_cnt_d;
      idx_q     <= idx_d;
      recall_q  <= recall_d;
      clear_q   <= clear_d;
    end
  end

  // Contents need no reset: lap_cnt_q is the only validity marker.
  always_ff @(posedge clk) begin
    if (wr_en) lap_mem_q[lap_cnt_q[IW-1:0]] <= i_count_value;
  end

`ifdef AUTO_HOLD_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer_q <= '0;
    end else if (state_q == ST_HOLD && state_d == ST_HOLD && !capture) begin
      timer_q <= timer_q + 32'd1;
    end else begin
      timer_q <= '0;
    end
  end
`endif

  assign o_run       = (state_q == ST_RUN) || (state_q == ST_HOLD);
  assign o_stop      = ~o_run;
  assign o_clear     = clear_q;
  assign o_value     = value_q;
  assign o_lap_count = lap_cnt_q;
  assign o_lap_full  = full;
  assign o_recall    = recall_q;

endmodule
